// File: rtl/pipe_pkg.sv
// pipe_pkg: stage-boundary payload widths and field offsets for packing the flat payload.
package pipe_pkg;
    localparam int XLEN       = 32;
    localparam int RD_W       = 5;
    localparam int ALU_OP_W   = 5;
    localparam int MEM_CTRL_W = 4;
    localparam int RD_LSB     = 0;
    localparam int ALU_OP_LSB = RD_LSB + RD_W;
    localparam int SRC1_LSB   = ALU_OP_LSB + ALU_OP_W;
    localparam int SRC2_LSB   = SRC1_LSB + XLEN;
    localparam int PC_LSB     = SRC2_LSB + XLEN;
    localparam int IMM_LSB    = PC_LSB + XLEN;
    localparam int MEM_LSB    = IMM_LSB + XLEN;
    localparam int IF_ID_W    = 2 * XLEN;
    localparam int ID_EXE_W   = MEM_LSB + MEM_CTRL_W;
    localparam int EXE_MEM_W  = RD_W + MEM_CTRL_W + 2 * XLEN;
    localparam int MEM_WB_W   = RD_W + 2 * XLEN;
    localparam int DEF_W      = 32;
    localparam int DEF_CNT_W  = 16;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream handshake, payload and stall statistics of one stage boundary.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic             flush;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_allowin;
    logic             ready_go;
    logic             out_allowin;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             stat_clr;
    logic [CNT_W-1:0] stall_cnt;
    modport slave (
        input  flush, in_valid, in_data, ready_go, out_allowin, stat_clr,
        output in_allowin, out_valid, out_data, stall_cnt
    );
    modport master (
        output flush, in_valid, in_data, ready_go, out_allowin, stat_clr,
        input  in_allowin, out_valid, out_data, stall_cnt
    );
endinterface

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_cnt #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [N-1:0] cnt_o
);
    logic [N-1:0] cnt_q;
    always_ff @(posedge clk)
        cnt_q <= (rst || clr_i) ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/allowin pipeline stage register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry that makes in_allowin a registered signal.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic              clk,
    input logic              rst,
    pipe_stage_reg_if.slave  bus
);
    logic         head_valid_q, head_valid_d;
    logic [W-1:0] head_data_q, head_data_d;
    logic         in_allowin, fire_in, fire_out;
    assign fire_in        = bus.in_valid & in_allowin;
    assign fire_out       = bus.out_valid & bus.out_allowin;
    assign bus.in_allowin = in_allowin;
    assign bus.out_valid  = head_valid_q & bus.ready_go;
    assign bus.out_data   = head_data_q;
`ifdef PIPE_STAGE_SKID_EN
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    assign in_allowin = !skid_valid_q;
    // The skid always holds the older entry, so it drains into head before new input does.
    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (bus.flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!head_valid_q || (fire_out && !skid_valid_q)) begin
            head_valid_d = fire_in;
            head_data_d  = fire_in ? bus.in_data : head_data_q;
        end else if (fire_out) begin
            head_data_d  = skid_data_q;
            skid_valid_d = fire_in;
            skid_data_d  = fire_in ? bus.in_data : skid_data_q;
        end else if (fire_in) begin
            skid_valid_d = 1'b1;
            skid_data_d  = bus.in_data;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign in_allowin = !head_valid_q | (bus.ready_go & bus.out_allowin);
    always_comb begin
        head_valid_d = bus.flush ? 1'b0 : fire_in ? 1'b1 : fire_out ? 1'b0 : head_valid_q;
        head_data_d  = (fire_in && !bus.flush) ? bus.in_data : head_data_q;
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
        end
    end
    pipe_sat_cnt #(.N(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.stat_clr),
        .inc_i (head_valid_q & !fire_out & !bus.flush),
        .cnt_o (bus.stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg against a queue model.
module tb_pipe_stage_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    pipe_stage_reg_if #(.W(32), .CNT_W(16)) bus ();
    pipe_stage_reg_if #(.W(8), .CNT_W(2)) bus1 ();
    pipe_stage_reg #(.W(32), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(bus));
    pipe_stage_reg #(.W(8), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    int tests = 0;
    int fails = 0;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    logic [31:0] mq[$];
    logic [31:0] m_hd = '0;
    int unsigned m_cnt = 0;

    function automatic bit m_allowin();
        return (CAP == 2) ? (mq.size() < 2) : (mq.size() == 0 || (bus.ready_go && bus.out_allowin));
    endfunction

    function automatic bit m_ov();
        return mq.size() != 0 && bus.ready_go;
    endfunction

    task automatic tick();
        bit fi, fo, inc;
        fi  = bus.in_valid && m_allowin();
        fo  = m_ov() && bus.out_allowin;
        inc = mq.size() != 0 && !fo && !bus.flush;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_hd  = '0;
            m_cnt = 0;
        end else begin
            if (bus.flush) mq.delete();
            else begin
                if (fo) void'(mq.pop_front());
                if (fi) mq.push_back(bus.in_data);
            end
            m_cnt = bus.stat_clr ? 0 : (inc && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            if (mq.size() != 0) m_hd = mq[0];
        end
        #1;
    endtask

    task automatic idle();
        bus.flush = 0; bus.in_valid = 0; bus.in_data = '0; bus.ready_go = 1; bus.out_allowin = 1; bus.stat_clr = 0;
        bus1.flush = 0; bus1.in_valid = 0; bus1.in_data = '0; bus1.ready_go = 1; bus1.out_allowin = 1; bus1.stat_clr = 0;
    endtask

    task automatic clr_cnt();
        bus.stat_clr = 1; tick(); bus.stat_clr = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; tick(); tick();
        rst = 0; #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid got %b exp 0", bus.out_valid); end
        tests++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL reset out_data got %h exp 0", bus.out_data); end
        tests++; if (bus.stall_cnt !== 16'h0) begin fails++; $display("FAIL reset stall_cnt got %0d exp 0", bus.stall_cnt); end
        tests++; if (bus.in_allowin !== 1'b1) begin fails++; $display("FAIL reset in_allowin got %b exp 1", bus.in_allowin); end
        tests++; if (bus1.stall_cnt !== 2'h0) begin fails++; $display("FAIL reset u1 stall_cnt got %0d exp 0", bus1.stall_cnt); end
    endtask

    task automatic test_stream();
        logic [31:0] d;
        idle();
        bus.in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            d = 32'h11 * (i + 1);
            bus.in_data = d; #1;
            tests++; if (bus.in_allowin !== 1'b1) begin fails++; $display("FAIL stream in_allowin[%0d] got %b exp 1", i, bus.in_allowin); end
            tick();
            tests++; if (bus.out_data !== d || bus.out_valid !== 1'b1) begin fails++; $display("FAIL stream out[%0d] got %b/%h exp 1/%h", i, bus.out_valid, bus.out_data, d); end
            tests++; if (bus.stall_cnt !== 16'h0) begin fails++; $display("FAIL stream stall_cnt got %0d exp 0", bus.stall_cnt); end
        end
        bus.in_valid = 0; tick();
    endtask

    task automatic test_hold();
        idle();
        bus.out_allowin = 0; bus.in_valid = 1; bus.in_data = 32'hAA; #1;
        tick();
        bus.in_valid = 0;
        for (int i = 0; i < 3; i++) tick();
        tests++; if (bus.out_data !== 32'hAA || bus.out_valid !== 1'b1) begin fails++; $display("FAIL hold out got %b/%h exp 1/aa", bus.out_valid, bus.out_data); end
        tests++; if (bus.stall_cnt !== 16'd3) begin fails++; $display("FAIL hold stall_cnt got %0d exp 3", bus.stall_cnt); end
        tests++; if (bus.in_allowin !== m_allowin()) begin fails++; $display("FAIL hold in_allowin got %b exp %b", bus.in_allowin, m_allowin()); end
        bus.out_allowin = 1; bus.in_valid = 1; bus.in_data = 32'hBB; #1;
        tests++; if (bus.in_allowin !== 1'b1) begin fails++; $display("FAIL hold release in_allowin got %b exp 1", bus.in_allowin); end
        tick();
        tests++; if (bus.out_data !== 32'hBB || bus.out_valid !== 1'b1) begin fails++; $display("FAIL hold next got %b/%h exp 1/bb", bus.out_valid, bus.out_data); end
        bus.in_valid = 0; tick();
        clr_cnt();
    endtask

    task automatic test_ready_go();
        idle();
        bus.in_valid = 1; bus.in_data = 32'h5; #1;
        tick();
        bus.in_valid = 0; bus.ready_go = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL ready_go out_valid[%0d] got %b exp 0", i, bus.out_valid); end
            tick();
        end
        tests++; if (bus.stall_cnt !== 16'd2) begin fails++; $display("FAIL ready_go stall_cnt got %0d exp 2", bus.stall_cnt); end
        bus.ready_go = 1; #1;
        tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h5) begin fails++; $display("FAIL ready_go release got %b/%h exp 1/5", bus.out_valid, bus.out_data); end
        tick();
        clr_cnt();
    endtask

    task automatic test_flush();
        idle();
        bus.out_allowin = 0; bus.in_valid = 1; bus.in_data = 32'h66; #1;
        tick();
        bus.flush = 1; bus.in_data = 32'h77; #1;
        tick();
        bus.flush = 0; bus.in_valid = 0; bus.out_allowin = 1; #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush out_valid got %b exp 0", bus.out_valid); end
        tests++; if (bus.out_data !== 32'h66) begin fails++; $display("FAIL flush out_data got %h exp 66", bus.out_data); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (bus.out_valid !== 1'b0 || bus.out_data === 32'h77) begin fails++; $display("FAIL flush drop[%0d] got %b/%h exp 0/not 77", i, bus.out_valid, bus.out_data); end
        end
        tests++; if (bus.stall_cnt !== 16'(m_cnt)) begin fails++; $display("FAIL flush stall_cnt got %0d exp %0d", bus.stall_cnt, m_cnt); end
        clr_cnt();
    endtask

    task automatic test_reset_mid_stall();
        idle();
        bus.out_allowin = 0; bus.in_valid = 1; bus.in_data = 32'h9; #1;
        tick(); tick();
        bus.in_valid = 0; rst = 1; bus.flush = 1; tick();
        rst = 0; bus.flush = 0; #1;
        tests++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin fails++; $display("FAIL rst_stall out got %b/%h exp 0/0", bus.out_valid, bus.out_data); end
        tests++; if (bus.stall_cnt !== 16'h0 || bus.in_allowin !== 1'b1) begin fails++; $display("FAIL rst_stall cnt/allowin got %0d/%b exp 0/1", bus.stall_cnt, bus.in_allowin); end
    endtask

    task automatic test_sat();
        int exp_sat[6] = '{1, 2, 3, 3, 3, 3};
        idle();
        bus1.out_allowin = 0; bus1.in_valid = 1; bus1.in_data = 8'h5; #1;
        tick();
        bus1.in_valid = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++; if (bus1.stall_cnt !== 2'(exp_sat[i])) begin fails++; $display("FAIL sat stall_cnt[%0d] got %0d exp %0d", i, bus1.stall_cnt, exp_sat[i]); end
        end
        bus1.stat_clr = 1; tick();
        bus1.stat_clr = 0;
        tests++; if (bus1.stall_cnt !== 2'd0) begin fails++; $display("FAIL sat clr got %0d exp 0", bus1.stall_cnt); end
        bus1.out_allowin = 1; tick();
    endtask

`ifdef PIPE_STAGE_SKID_EN
    task automatic test_skid();
        idle();
        bus.out_allowin = 0; bus.in_valid = 1; bus.in_data = 32'h1; #1;
        tests++; if (bus.in_allowin !== 1'b1) begin fails++; $display("FAIL skid allowin first got %b exp 1", bus.in_allowin); end
        tick();
        bus.in_data = 32'h2; #1;
        tests++; if (bus.in_allowin !== 1'b1) begin fails++; $display("FAIL skid allowin second got %b exp 1", bus.in_allowin); end
        tick();
        bus.in_valid = 0; bus.out_allowin = 1; #1;
        tests++; if (bus.in_allowin !== 1'b0) begin fails++; $display("FAIL skid full allowin got %b exp 0", bus.in_allowin); end
        tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1) begin fails++; $display("FAIL skid first out got %b/%h exp 1/1", bus.out_valid, bus.out_data); end
        tick();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h2) begin fails++; $display("FAIL skid second out got %b/%h exp 1/2", bus.out_valid, bus.out_data); end
        tests++; if (bus.in_allowin !== 1'b1) begin fails++; $display("FAIL skid drained allowin got %b exp 1", bus.in_allowin); end
        tick();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL skid empty out_valid got %b exp 0", bus.out_valid); end
        clr_cnt();
    endtask
`endif

    task automatic test_random();
        idle();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid    = $urandom_range(0, 1);
            bus.in_data     = $urandom;
            bus.ready_go    = $urandom_range(0, 3) != 0;
            bus.out_allowin = $urandom_range(0, 2) != 0;
            bus.flush       = $urandom_range(0, 15) == 0;
            bus.stat_clr    = $urandom_range(0, 31) == 0;
            #1;
            tests++; if (bus.in_allowin !== m_allowin()) begin fails++; $display("FAIL rand[%0d] in_allowin got %b exp %b", i, bus.in_allowin, m_allowin()); end
            tests++; if (bus.out_valid !== m_ov()) begin fails++; $display("FAIL rand[%0d] out_valid got %b exp %b", i, bus.out_valid, m_ov()); end
            tests++; if (bus.out_data !== m_hd) begin fails++; $display("FAIL rand[%0d] out_data got %h exp %h", i, bus.out_data, m_hd); end
            tests++; if (bus.stall_cnt !== 16'(m_cnt)) begin fails++; $display("FAIL rand[%0d] stall_cnt got %0d exp %0d", i, bus.stall_cnt, m_cnt); end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_ready_go();
        test_flush();
        test_sat();
`ifdef PIPE_STAGE_SKID_EN
        test_skid();
`endif
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed always-load ID/EXE-style registers between CPU stages. It adds:
- a valid/allowin handshake, so a stage holds its instruction while stalled;
- a per-stage ready_go for multi-cycle operations;
- a flush for branch and exception redirects;
- a saturating stall counter;
- an optional skid entry that registers the upstream allowin path.

One instance sits at each stage boundary (IF/ID, ID/EXE, EXE/MEM, MEM/WB). The payload is a flat bus whose width is set per boundary.

## Interface
- W, 32: payload width in bits (1..512).
- CNT_W, 16: stall counter width (1..32).
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard every entry held in this stage.
- in_valid  in  1  upstream offers a payload.
- in_data  in  W  upstream payload.
- in_allowin  out  1  this stage accepts a payload this cycle.
- ready_go  in  1  local stage logic has finished with the head entry.
- out_allowin  in  1  downstream accepts this cycle.
- out_valid  out  1  head entry is valid and ready_go is high.
- out_data  out  W  head entry payload.
- stat_clr  in  1  clear stall counter.
- stall_cnt  out  CNT_W  saturating stall-cycle count.

## Operation
Transfer definitions:
- fire_in = in_valid & in_allowin.
- fire_out = out_valid & out_allowin.

Head entry:
- Head entry consists of head_valid and head_data.
- out_valid = head_valid & ready_go. This is combinational from ready_go.
- out_data = head_data.

Base mode (no skid):
- in_allowin = !head_valid | (ready_go & out_allowin). This is combinational.
- On fire_in: head_data <= in_data and head_valid <= 1.
- On fire_out without fire_in: head_valid <= 0.
- On fire_out and fire_in in the same cycle: head is replaced. Throughput is 1 per cycle.
- head_data loads only on fire_in. A stalled entry holds its value.

Flush:
- Flush clears head_valid, and skid_valid when the skid is compiled in.
- Flush overrides fire_in. A payload offered in the flush cycle is dropped, and upstream treats it as consumed.
- Data registers are not cleared by flush.

Stall counter:
- Increments when head_valid & !fire_out & !flush.
- Saturates at 2^CNT_W-1 and does not wrap.
- stat_clr zeroes the counter. If stat_clr and the increment condition occur together, the counter reads 0.

## Timing
- Reset values: out_valid=0, out_data=0, stall_cnt=0, and skid_valid=0 when present. in_allowin is 1 during the cycle after reset deasserts.
- Latency: a payload accepted on edge N is visible on out_data after edge N. out_valid follows if ready_go is high.
- Reset taken mid-stall discards all entries.
- Flush and rst in the same cycle behave as rst.
- ready_go low with out_allowin high: no transfer out. Base mode then has in_allowin = 0.
- Base mode: in_allowin depends combinationally on out_allowin. A chain of N stages forms a combinational ready path N stages long.

## Configuration
The feature is controlled by the macro PIPE_STAGE_SKID_EN.

Without the macro:
- Behaviour is exactly the base mode above.

With the macro, a second entry (skid_valid, skid_data) is added:
- in_allowin = !skid_valid. This is a registered signal with no combinational path from out_allowin or ready_go.
- Each edge, if not flushing:
  - Head empty: fire_in loads head.
  - Head valid and fire_out, skid valid: skid moves to head and skid_valid <= 0. A simultaneous fire_in loads the skid.
  - Head valid and fire_out, skid empty: fire_in loads head. Otherwise head_valid <= 0.
  - Head valid and no fire_out: fire_in loads the skid.
- Order is always preserved: skid is older than any new input.
- Full condition is head and skid both valid. in_allowin then stays 0 until a fire_out.
- Latency stays 1 cycle when the skid is empty.

## Structure
- Shared package pipe_pkg holds:
  - boundary payload widths IF_ID_W, ID_EXE_W, EXE_MEM_W, MEM_WB_W;
  - field offset constants used to pack and unpack the flat payload (rd, alu_op, src1, src2, pc, imm, mem controls).
- One sub-module, pipe_sat_cnt: parametrised saturating counter with clr and inc inputs, used for stall_cnt.

## Test plan
- Base mode, W=32, ready_go=1, out_allowin=1, in_valid high for 4 cycles with 0x11..0x44 → out_data is 0x11..0x44 on consecutive cycles, in_allowin=1 throughout, stall_cnt=0.
- Hold 0xAA in head, out_allowin=0 for 3 cycles → out_data stays 0xAA, in_allowin=0, stall_cnt=3. Then out_allowin=1 → 0xAA leaves and the next input is accepted in the same cycle.
- ready_go=0 for 2 cycles with head=0x5 → out_valid=0 for both cycles, stall_cnt=2. Then ready_go=1 → out_valid=1.
- flush asserted while in_valid=1 with 0x77 and head=0x66 → next cycle out_valid=0. 0x77 never appears on out_data.
- CNT_W=2, stall for 6 cycles → stall_cnt is 1,2,3,3,3,3. Then stat_clr → 0.
- PIPE_STAGE_SKID_EN, out_allowin=0, push 0x1 then 0x2 → in_allowin drops to 0 after the second accept. Release → output order 0x1, 0x2, and in_allowin returns to 1 one cycle after the skid drains.
